// File: rtl/snax_hwpe_tcdm_responder.sv
// snax_hwpe_tcdm_responder: single-port TCDM slave model for HWPE masters.
// Optional SNAX_TCDM_RESP_OOR_CHECK_EN flags and drops out-of-range accesses.

module snax_hwpe_tcdm_responder #(
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned NumWords       = 256,
    parameter int unsigned RspLatency     = 1,
    parameter int unsigned GntStallPeriod = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic [AddrWidth-1:0]   add_i,
    input  logic                   wen_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [DataWidth-1:0]   data_i,
    output logic [DataWidth-1:0]   r_data_o,
    output logic                   r_valid_o,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned OffW    = $clog2(BeWidth);
    localparam int unsigned IdxW    = $clog2(NumWords);
    localparam int unsigned CntW    = $clog2(GntStallPeriod + 2);

    logic [CntW-1:0]      gnt_cnt;
    logic                 stall;
    logic                 accept;
    logic [AddrWidth-1:0] word_addr;
    logic [IdxW-1:0]      idx;
    logic                 oor;
    logic                 unused_addr;
    logic [DataWidth-1:0] rsp_d;

    logic [DataWidth-1:0] mem [NumWords];
    logic [RspLatency-1:0] vld_q;
    logic [DataWidth-1:0] dat_q [RspLatency];

    assign word_addr   = add_i >> OffW;
    assign idx         = word_addr[IdxW-1:0];
    assign unused_addr = ^word_addr;

`ifdef SNAX_TCDM_RESP_OOR_CHECK_EN
    assign oor = |(word_addr >> IdxW);
`else
    assign oor = 1'b0;
`endif

    assign stall  = (GntStallPeriod != 0) &&
                    (gnt_cnt == CntW'(GntStallPeriod));
    assign gnt_o  = req_i & ~stall & ~rst_i;
    assign accept = gnt_o;

    // Grant counter: one denied request cycle after every GntStallPeriod grants.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt_cnt <= '0;
        end else if (req_i) begin
            if (stall) begin
                gnt_cnt <= '0;
            end else if (GntStallPeriod != 0) begin
                gnt_cnt <= gnt_cnt + 1'b1;
            end
        end
    end

    // Byte-masked write into the backing store; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (accept && !wen_i && !oor) begin
            for (int b = 0; b < BeWidth; b++) begin
                if (be_i[b]) begin
                    mem[idx][8*b +: 8] <= data_i[8*b +: 8];
                end
            end
        end
    end

    // Read data is sampled at the grant edge; writes and misses answer zero.
    always_comb begin
        rsp_d = '0;
        if (accept && wen_i && !oor) begin
            rsp_d = mem[idx];
        end
    end

    // Response shift pipeline, RspLatency stages deep, one slot per cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int i = 0; i < RspLatency; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= accept;
            dat_q[0] <= rsp_d;
            for (int i = 1; i < RspLatency; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign r_valid_o = vld_q[RspLatency-1];
    assign r_data_o  = vld_q[RspLatency-1] ? dat_q[RspLatency-1] : '0;
    assign busy_o    = |vld_q;

`ifdef SNAX_TCDM_RESP_OOR_CHECK_EN
    logic err_q;

    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (accept && oor) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: doc/snax_hwpe_tcdm_responder.md
SNAX_HWPE_TCDM_RESPONDER -- requirements
Module: snax_hwpe_tcdm_responder

Interface
REQ-001 SHALL have parameter DataWidth, default 32, TCDM word width in bits (multiple of 8).
REQ-002 SHALL have parameter AddrWidth, default 32, byte address width.
REQ-003 SHALL have parameter NumWords, default 256, backing-store depth in words (power of two, at least 2).
REQ-004 SHALL have parameter RspLatency, default 1, grant-to-r_valid latency in cycles (legal range 1..4).
REQ-005 SHALL have parameter GntStallPeriod, default 0; 0 means never stall, N>0 means one denied cycle after every N grants.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port req_i, input, 1 bit: request valid from the HWPE TCDM master.
REQ-009 SHALL have port gnt_o, output, 1 bit: request accepted this cycle.
REQ-010 SHALL have port add_i, input, AddrWidth bits: byte address.
REQ-011 SHALL have port wen_i, input, 1 bit: 1 = read, 0 = write (HWPE convention).
REQ-012 SHALL have port be_i, input, DataWidth/8 bits: byte enables for writes.
REQ-013 SHALL have port data_i, input, DataWidth bits: write data.
REQ-014 SHALL have port r_data_o, output, DataWidth bits: response data.
REQ-015 SHALL have port r_valid_o, output, 1 bit: response valid; no ready, master always accepts.
REQ-016 SHALL have port busy_o, output, 1 bit: at least one response in flight.
REQ-017 SHALL have port err_o, output, 1 bit: sticky out-of-range flag (see Configuration).

Function
REQ-018 SHALL drive gnt_o = req_i AND NOT stall combinationally; a transaction is accepted on a cycle with req_i=1 and gnt_o=1.
REQ-019 SHALL keep a grant counter when GntStallPeriod>0: it increments on each accepted transaction; when it equals GntStallPeriod, stall=1, gnt_o=0 for exactly one req_i-high cycle and the counter clears; cycles with req_i=0 leave it unchanged.
REQ-020 SHALL compute word index = add_i >> log2(DataWidth/8); low byte-offset bits are ignored.
REQ-021 SHALL, on an accepted write, update only bytes with be_i=1 at the clock edge ending the grant cycle; be_i=0 writes leave memory unchanged but still respond.
REQ-022 SHALL, on an accepted read, capture the word at the grant edge so that a read accepted in cycle N+1 returns data written in cycle N.
REQ-023 SHALL assert r_valid_o for exactly one cycle, RspLatency cycles after every accepted transaction (read or write); r_data_o = read data for reads and 0 for writes.
REQ-024 SHALL sustain one accepted transaction per cycle, with responses delivered in acceptance order through a RspLatency-deep valid/data shift pipeline; no backpressure exists.
REQ-025 SHALL drive r_data_o = 0 whenever r_valid_o = 0.
REQ-026 SHALL drive busy_o = OR of all pipeline valid bits.
REQ-027 SHALL, when req_i=0, neither alter memory nor the pipeline input (a bubble enters).

Reset
REQ-028 SHALL, with rst_i=1 at a clock edge, clear all pipeline valid bits, the grant counter and err_o; r_valid_o=0, r_data_o=0, busy_o=0 the following cycle.
REQ-029 SHALL drop in-flight responses on reset mid-operation; memory contents are not reset and are undefined until written.
REQ-030 SHALL force gnt_o=0 while rst_i=1 and ignore requests in that cycle.

Configuration
REQ-031 SHALL recognise macro SNAX_TCDM_RESP_OOR_CHECK_EN.
REQ-032 SHALL, with the macro defined, treat word index >= NumWords as out-of-range: grant and respond normally, drop the write, return 0 for a read, and set err_o sticky at the grant edge.
REQ-033 SHALL, without the macro, tie err_o=0 and wrap the index modulo NumWords.

Verification
REQ-034 SHALL verify: RspLatency=1, write 0xA5A5A5A5 to 0x10 with be=0xF, then read 0x10 -> read r_valid_o at grant+1 with r_data_o=0xA5A5A5A5; write response has r_data_o=0.
REQ-035 SHALL verify: write 0xFFFFFFFF, then write 0x12345678 with be=0b0101, then read -> 0xFF34FF78.
REQ-036 SHALL verify: RspLatency=3, 8 back-to-back reads -> 8 consecutive r_valid_o pulses starting 3 cycles after the first grant, in order, with busy_o high throughout.
REQ-037 SHALL verify: GntStallPeriod=2 with req_i held high for 6 cycles -> gnt_o pattern 1,1,0,1,1,0.
REQ-038 SHALL verify: with the macro defined and NumWords=256, read 0x400 -> r_data_o=0 and err_o=1 until rst_i; without the macro, the same read returns the word at 0x000.
REQ-039 SHALL verify: rst_i asserted with 2 responses in flight -> no r_valid_o pulses after the reset edge, and busy_o=0.
